// File: rtl/sorted_writer_if.sv
// Load-side bus of the sorted writer: value handshake, clear, RAM write port and status.
interface sorted_writer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              clear;
  logic [ADDR_W-1:0] address;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] q;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;

  // Producer and RAM side
  modport master (
    output in_valid, in_data, clear, q,
    input  in_ready, address, wr_en, wr_data, count, full, busy
  );

  // Sorted writer side
  modport slave (
    input  in_valid, in_data, clear, q,
    output in_ready, address, wr_en, wr_data, count, full, busy
  );
endinterface

// File: rtl/sorted_writer.sv
// Insertion-sorts incoming values into a single-port RAM, shifting larger entries up one slot
// at a time until the new value's slot is found.
module sorted_writer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input logic            clk,
  input logic            reset_n,
  sorted_writer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StCmp, StPlace} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ADDR_W:0]   pos_q, pos_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   pos_dec;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              in_ready;
  logic              full;

  assign pos_dec = pos_q - 1'b1;
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));

  // Next-state, RAM port and handshake decode
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    pos_d    = pos_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wr_en    = 1'b0;
    wr_data  = val_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = !full && !bus.clear;
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.in_valid && in_ready) begin
          val_d   = bus.in_data;
          pos_d   = count_q;
          state_d = (count_q == '0) ? StPlace : StRead;
        end
      end
      StRead: begin
        addr_d  = pos_dec[ADDR_W-1:0];
        state_d = StCmp;
      end
      StCmp: begin
        // q is RAM[pos-1]; a strictly larger entry moves up, equal ones stay below the new value
        if (bus.q > val_q) begin
          addr_d  = pos_q[ADDR_W-1:0];
          wr_data = bus.q;
          wr_en   = 1'b1;
          pos_d   = pos_dec;
          state_d = (pos_dec == '0) ? StPlace : StRead;
        end else begin
          state_d = StPlace;
        end
      end
      StPlace: begin
        addr_d  = pos_q[ADDR_W-1:0];
        wr_data = val_q;
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; address is held between accesses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      val_q   <= '0;
      pos_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      pos_q   <= pos_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.address  = addr_d;
  assign bus.wr_en    = wr_en;
  assign bus.wr_data  = wr_data;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.busy     = (state_q != StIdle);

endmodule
